// File: rtl/arb_pkg.sv
// Shared types and width helpers for the hold-while-requesting arbiter family.
package arb_pkg;

  typedef enum logic {
    ARB_IDLE    = 1'b0,
    ARB_GRANTED = 1'b1
  } arb_state_t;

  // Index width for an n-entry vector; never narrower than one bit.
  function automatic int ARB_IDX_W(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Hold counter width: must be able to hold the value max_hold itself.
  function automatic int ARB_HOLD_W(input int max_hold);
    return (max_hold < 1) ? 1 : $clog2(max_hold + 1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Circular first-set-bit search: lowest set bit of vec at or after start, wrapping.
module rr_pick
  import arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]              vec,
  input  logic [ARB_IDX_W(N)-1:0]   start,
  output logic                      found,
  output logic [ARB_IDX_W(N)-1:0]   idx
);

  localparam int W = ARB_IDX_W(N);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [W-1:0]   offset;
  logic           hit;
  logic [W:0]     sum;

  always_comb begin
    // Shifting the doubled vector right by start rotates vec so start lands at bit 0.
    dbl    = {vec, vec} >> start;
    rot    = dbl[N-1:0];
    hit    = 1'b0;
    offset = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!hit && rot[i]) begin
        hit    = 1'b1;
        offset = W'(i);
      end
    end
    sum = {1'b0, start} + {1'b0, offset};
    if (sum >= (W+1)'(N)) begin
      sum = sum - (W+1)'(N);
    end
    found = hit;
    idx   = sum[W-1:0];
  end

endmodule

// File: rtl/rr_hold_arbiter.sv
// N-requester sticky-grant arbiter: round-robin or fixed priority, with an
// optional bounded hold time that forces a handoff when others are waiting.
module rr_hold_arbiter
  import arb_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int MAX_HOLD = 8,
  parameter int RR_EN    = 1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [N_REQ-1:0]            req,
  output logic [N_REQ-1:0]            grant,
  output logic                        grant_valid,
  output logic [ARB_IDX_W(N_REQ)-1:0] grant_id,
  output logic                        grant_new
);

  localparam int IDX_W = ARB_IDX_W(N_REQ);
  localparam int HC_W  = ARB_HOLD_W(MAX_HOLD);

  arb_state_t       state, state_nxt;
  logic [N_REQ-1:0] grant_nxt;
  logic             valid_nxt;
  logic [IDX_W-1:0] id_nxt;
  logic             new_nxt;
  logic [IDX_W-1:0] ptr, ptr_nxt;
  logic [HC_W-1:0]  hold_cnt, hold_nxt;

  logic [N_REQ-1:0] owner_oh;
  logic             owner_req;
  logic [IDX_W-1:0] owner_inc;
  logic             expired;
  logic             take;

  logic [IDX_W-1:0] pick_start;
  logic [N_REQ-1:0] pick_vec;
  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] v);
    return (v == IDX_W'(N_REQ - 1)) ? '0 : v + IDX_W'(1);
  endfunction

  assign owner_oh  = {{(N_REQ-1){1'b0}}, 1'b1} << grant_id;
  assign owner_req = |(req & owner_oh);
  assign owner_inc = wrap_inc(grant_id);
  assign expired   = (MAX_HOLD != 0) && (hold_cnt == HC_W'(MAX_HOLD));

  // One shared search; only its start point and mask depend on the decision kind.
  always_comb begin
    pick_start = '0;
    pick_vec   = req;
    if (state == ARB_IDLE) begin
      if (RR_EN != 0) pick_start = ptr;
    end else begin
      pick_vec = req & ~owner_oh;
      if (!owner_req) begin
        if (RR_EN != 0) pick_start = owner_inc;
      end else begin
        // Forced handoff searches after the owner in both modes.
        pick_start = owner_inc;
      end
    end
  end

  rr_pick #(.N(N_REQ)) u_pick (
    .vec   (pick_vec),
    .start (pick_start),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    valid_nxt = grant_valid;
    id_nxt    = grant_id;
    new_nxt   = 1'b0;
    ptr_nxt   = ptr;
    hold_nxt  = hold_cnt;
    take      = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (pick_found) take = 1'b1;
      end
      ARB_GRANTED: begin
        if (!owner_req) begin
          if (pick_found) begin
            take = 1'b1;
          end else begin
            state_nxt = ARB_IDLE;
            grant_nxt = '0;
            valid_nxt = 1'b0;
          end
        end else if (expired && pick_found) begin
          take = 1'b1;
        end else if ((MAX_HOLD != 0) && !expired) begin
          hold_nxt = hold_cnt + HC_W'(1);
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
    if (take) begin
      state_nxt = ARB_GRANTED;
      grant_nxt = {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
      valid_nxt = 1'b1;
      id_nxt    = pick_idx;
      new_nxt   = 1'b1;
      ptr_nxt   = wrap_inc(pick_idx);
      hold_nxt  = HC_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ARB_IDLE;
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      grant_new   <= 1'b0;
      ptr         <= '0;
      hold_cnt    <= '0;
    end else begin
      state       <= state_nxt;
      grant       <= grant_nxt;
      grant_valid <= valid_nxt;
      grant_id    <= id_nxt;
      grant_new   <= new_nxt;
      ptr         <= ptr_nxt;
      hold_cnt    <= hold_nxt;
    end
  end

endmodule

// File: tb/tb_rr_hold_arbiter.sv
// Directed bench: three arbiter configurations (RR no-limit, RR hold=3, fixed no-limit).
module tb_rr_hold_arbiter;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic [3:0] req_a, grant_a, req_b, grant_b, req_c, grant_c;
  logic       valid_a, new_a, valid_b, new_b, valid_c, new_c;
  logic [1:0] id_a, id_b, id_c;

  int passed = 0;
  int total  = 0;

  rr_hold_arbiter #(.N_REQ(4), .MAX_HOLD(0), .RR_EN(1)) dut_a (
    .clock(clock), .reset(reset), .req(req_a), .grant(grant_a),
    .grant_valid(valid_a), .grant_id(id_a), .grant_new(new_a));

  rr_hold_arbiter #(.N_REQ(4), .MAX_HOLD(3), .RR_EN(1)) dut_b (
    .clock(clock), .reset(reset), .req(req_b), .grant(grant_b),
    .grant_valid(valid_b), .grant_id(id_b), .grant_new(new_b));

  rr_hold_arbiter #(.N_REQ(4), .MAX_HOLD(0), .RR_EN(0)) dut_c (
    .clock(clock), .reset(reset), .req(req_c), .grant(grant_c),
    .grant_valid(valid_c), .grant_id(id_c), .grant_new(new_c));

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_a = '0; req_b = '0; req_c = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Expected packing everywhere: {grant[3:0], grant_valid, grant_id[1:0], grant_new}.
  task automatic test_reset();
    do_reset();
    for (int c = 1; c <= 5; c++) begin
      tick();
      total++;
      if ({grant_a, valid_a, id_a, new_a} !== 8'h00) $display("FAIL reset_idle_a c=%0d got=%b want=00000000", c, {grant_a, valid_a, id_a, new_a});
      else passed++;
      total++;
      if ({grant_b, valid_b, id_b, new_b} !== 8'h00) $display("FAIL reset_idle_b c=%0d got=%b want=00000000", c, {grant_b, valid_b, id_b, new_b});
      else passed++;
      total++;
      if ({grant_c, valid_c, id_c, new_c} !== 8'h00) $display("FAIL reset_idle_c c=%0d got=%b want=00000000", c, {grant_c, valid_c, id_c, new_c});
      else passed++;
    end
  endtask

  task automatic test_hold();
    logic [7:0] exp;
    do_reset();
    req_a = 4'b0010;
    for (int c = 1; c <= 20; c++) begin
      tick();
      exp = {4'b0010, 1'b1, 2'd1, (c == 1)};
      total++;
      if ({grant_a, valid_a, id_a, new_a} !== exp) $display("FAIL hold c=%0d got=%b want=%b", c, {grant_a, valid_a, id_a, new_a}, exp);
      else passed++;
    end
    req_a = 4'b0000;
    tick();
    total++;
    if ({grant_a, valid_a, new_a} !== 6'b000000) $display("FAIL hold_release got=%b want=000000", {grant_a, valid_a, new_a});
    else passed++;
  endtask

  task automatic test_no_limit();
    logic [7:0] exp;
    do_reset();
    req_a = 4'b0011;
    for (int c = 1; c <= 12; c++) begin
      tick();
      exp = {4'b0001, 1'b1, 2'd0, (c == 1)};
      total++;
      if ({grant_a, valid_a, id_a, new_a} !== exp) $display("FAIL no_limit c=%0d got=%b want=%b", c, {grant_a, valid_a, id_a, new_a}, exp);
      else passed++;
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] order [5];
    logic [3:0] oh;
    order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    do_reset();
    req_a = 4'b1111;
    tick();
    for (int i = 0; i < 5; i++) begin
      oh = 4'b0001 << order[i];
      total++;
      if ({grant_a, valid_a, id_a, new_a} !== {oh, 1'b1, order[i], 1'b1}) $display("FAIL rr_first i=%0d got=%b want=%b", i, {grant_a, valid_a, id_a, new_a}, {oh, 1'b1, order[i], 1'b1});
      else passed++;
      req_a = 4'b1111;
      tick();
      total++;
      if ({grant_a, valid_a, id_a, new_a} !== {oh, 1'b1, order[i], 1'b0}) $display("FAIL rr_second i=%0d got=%b want=%b", i, {grant_a, valid_a, id_a, new_a}, {oh, 1'b1, order[i], 1'b0});
      else passed++;
      req_a = 4'b1111 & ~oh;
      tick();
    end
    req_a = 4'b0000;
  endtask

  task automatic test_idle_ptr();
    do_reset();
    req_a = 4'b0010;
    tick();
    total++;
    if ({grant_a, valid_a, id_a, new_a} !== 8'b0010_1_01_1) $display("FAIL idle_ptr_first got=%b want=00101011", {grant_a, valid_a, id_a, new_a});
    else passed++;
    req_a = 4'b0000;
    tick();
    total++;
    if ({grant_a, valid_a, new_a} !== 6'b000000) $display("FAIL idle_ptr_idle got=%b want=000000", {grant_a, valid_a, new_a});
    else passed++;
    total++;
    if (id_a !== 2'd1) $display("FAIL idle_id_hold got=%0d want=1", id_a);
    else passed++;
    req_a = 4'b1010;
    tick();
    total++;
    if ({grant_a, valid_a, id_a, new_a} !== 8'b1000_1_11_1) $display("FAIL idle_ptr_rr got=%b want=10001111", {grant_a, valid_a, id_a, new_a});
    else passed++;
  endtask

  task automatic test_regrant();
    req_a = 4'b0000;
    tick();
    total++;
    if (valid_a !== 1'b0) $display("FAIL regrant_gap valid=%b want=0", valid_a);
    else passed++;
    req_a = 4'b1000;
    tick();
    total++;
    if ({grant_a, valid_a, id_a, new_a} !== 8'b1000_1_11_1) $display("FAIL regrant got=%b want=10001111", {grant_a, valid_a, id_a, new_a});
    else passed++;
  endtask

  task automatic test_timeout();
    logic [1:0] eid;
    logic [7:0] exp;
    do_reset();
    req_b = 4'b0011;
    for (int c = 1; c <= 9; c++) begin
      tick();
      eid = 2'(((c - 1) / 3) % 2);
      exp = {4'b0001 << eid, 1'b1, eid, ((c - 1) % 3 == 0)};
      total++;
      if ({grant_b, valid_b, id_b, new_b} !== exp) $display("FAIL timeout c=%0d got=%b want=%b", c, {grant_b, valid_b, id_b, new_b}, exp);
      else passed++;
    end
  endtask

  task automatic test_saturate();
    do_reset();
    req_b = 4'b0001;
    for (int c = 1; c <= 5; c++) begin
      tick();
      total++;
      if ({grant_b, valid_b, id_b, new_b} !== {4'b0001, 1'b1, 2'd0, (c == 1)}) $display("FAIL sat_hold c=%0d got=%b want=%b", c, {grant_b, valid_b, id_b, new_b}, {4'b0001, 1'b1, 2'd0, (c == 1)});
      else passed++;
    end
    req_b = 4'b0011;
    tick();
    total++;
    if ({grant_b, valid_b, id_b, new_b} !== 8'b0010_1_01_1) $display("FAIL sat_handoff got=%b want=00101011", {grant_b, valid_b, id_b, new_b});
    else passed++;
  endtask

  task automatic test_fixed();
    do_reset();
    req_c = 4'b1100;
    tick();
    total++;
    if ({grant_c, valid_c, id_c, new_c} !== 8'b0100_1_10_1) $display("FAIL fixed_first got=%b want=01001101", {grant_c, valid_c, id_c, new_c});
    else passed++;
    req_c = 4'b1001;
    tick();
    total++;
    if ({grant_c, valid_c, id_c, new_c} !== 8'b0001_1_00_1) $display("FAIL fixed_handoff got=%b want=00011001", {grant_c, valid_c, id_c, new_c});
    else passed++;
    tick();
    total++;
    if ({grant_c, valid_c, id_c, new_c} !== 8'b0001_1_00_0) $display("FAIL fixed_keep got=%b want=00011000", {grant_c, valid_c, id_c, new_c});
    else passed++;
    req_c = 4'b0000;
    tick();
    total++;
    if ({grant_c, valid_c, new_c} !== 6'b000000) $display("FAIL fixed_idle got=%b want=000000", {grant_c, valid_c, new_c});
    else passed++;
    req_c = 4'b1001;
    tick();
    total++;
    if ({grant_c, valid_c, id_c, new_c} !== 8'b0001_1_00_1) $display("FAIL fixed_lowest got=%b want=00011001", {grant_c, valid_c, id_c, new_c});
    else passed++;
    req_c = 4'b1000;
    tick();
    total++;
    if ({grant_c, valid_c, id_c, new_c} !== 8'b1000_1_11_1) $display("FAIL fixed_release got=%b want=10001111", {grant_c, valid_c, id_c, new_c});
    else passed++;
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    req_a = 4'b1000;
    tick();
    total++;
    if ({grant_a, valid_a, id_a, new_a} !== 8'b1000_1_11_1) $display("FAIL mid_owner got=%b want=10001111", {grant_a, valid_a, id_a, new_a});
    else passed++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++;
    if ({grant_a, valid_a, id_a, new_a} !== 8'h00) $display("FAIL mid_reset got=%b want=00000000", {grant_a, valid_a, id_a, new_a});
    else passed++;
    req_a = 4'b1010;
    tick();
    total++;
    if ({grant_a, valid_a, id_a, new_a} !== 8'b0010_1_01_1) $display("FAIL mid_after got=%b want=00101011", {grant_a, valid_a, id_a, new_a});
    else passed++;
  endtask

  initial begin
    reset = 1'b1;
    req_a = '0; req_b = '0; req_c = '0;
    test_reset();
    test_hold();
    test_no_limit();
    test_round_robin();
    test_idle_ptr();
    test_regrant();
    test_timeout();
    test_saturate();
    test_fixed();
    test_reset_mid_grant();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
